mem_lsu: RTL and testbench

Memory-stage load/store unit that sits directly upstream of the word-addressed data memory `dmem`. The memory writes only whole 32-bit words, so this unit turns byte (SB) and halfword (SH) stores into a two-cycle read-modify-write. It stalls the pipeline for the extra cycle. Loads, word stores and the sub-word load size code pass straight through, and the unit optionally traps misaligned accesses.

---
 rtl/mips_lsu_pkg.sv | 18 +
 rtl/store_merge.sv | 33 +++
 rtl/mem_lsu.sv | 93 +++++++++
 tb/tb_mem_lsu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: access size codes,
// FSM state encoding and a small size-classification helper.
package mips_lsu_pkg;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } lsu_state_e;

  function automatic logic is_subword(input logic [1:0] sz);
    return (sz == SZ_BYTE) || (sz == SZ_HALF);
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational byte/halfword insertion of right-justified store data into an
// existing memory word; word-size accesses replace the whole word.
module store_merge
  import mips_lsu_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  bytes,
  input  logic [1:0]  lane,
  output logic [31:0] new_word
);

  always_comb begin
    new_word = old_word;
    case (bytes)
      SZ_BYTE: begin
        case (lane)
          2'd0:    new_word[7:0]   = wdata[7:0];
          2'd1:    new_word[15:8]  = wdata[7:0];
          2'd2:    new_word[23:16] = wdata[7:0];
          default: new_word[31:24] = wdata[7:0];
        endcase
      end
      // Halfword lane is chosen by lane[1] alone; lane[0] is don't-care here.
      SZ_HALF: begin
        if (lane[1]) new_word[31:16] = wdata[15:0];
        else         new_word[15:0]  = wdata[15:0];
      end
      default: new_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: passes loads and word stores straight to dmem and
// turns byte/half stores into a two-cycle read-modify-write with a one-cycle stall.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module mem_lsu
  import mips_lsu_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          memwrite,
  input  logic [1:0]    bytes,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          stall,
  output logic          misalign,
  output logic [AW-1:0] dm_a,
  output logic          dm_we,
  output logic [31:0]   dm_wd,
  output logic [1:0]    dm_bytes,
  input  logic [31:0]   dm_rd,
  input  logic [31:0]   dm_rawd
);

  lsu_state_e    state;
  logic [AW-1:0] addr_p1;
  logic [31:0]   wd_p1;
  logic [31:0]   merged;
  logic          trap;
  logic          sub_store;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = req & (((bytes == SZ_HALF) & addr[0]) |
                       (((bytes == SZ_WORD) | (bytes == 2'd3)) & (addr[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  assign misalign  = (state == ST_IDLE) & trap;
  assign sub_store = req & memwrite & is_subword(bytes) & ~trap;
  assign rdata     = dm_rd;

  store_merge u_merge (
    .old_word (dm_rawd),
    .wdata    (wdata),
    .bytes    (bytes),
    .lane     (addr[1:0]),
    .new_word (merged)
  );

  always_comb begin
    dm_a     = addr;
    dm_bytes = bytes;
    dm_wd    = wdata;
    dm_we    = 1'b0;
    stall    = 1'b0;
    if (state == ST_WRITE) begin
      dm_a     = addr_p1;
      dm_wd    = wd_p1;
      dm_bytes = SZ_WORD;
      // A reset landing on the write cycle must abort the pending write.
      dm_we    = ~reset;
    end else if (sub_store) begin
      dm_bytes = SZ_WORD;
      stall    = 1'b1;
    end else if (req & memwrite & ~trap) begin
      dm_we = 1'b1;
    end
  end

  // Stage p1: captured address and merged word for the write half of the RMW
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      addr_p1 <= '0;
      wd_p1   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sub_store) begin
            addr_p1 <= addr;
            wd_p1   <= merged;
            state   <= ST_WRITE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu with a small word-addressed dmem model and a
// byte-level reference memory; checks stall/strobe behaviour and memory contents.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        memwrite;
  logic [1:0]  bytes;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic [31:0] dm_a;
  logic        dm_we;
  logic [31:0] dm_wd;
  logic [1:0]  dm_bytes;
  logic [31:0] dm_rd;
  logic [31:0] dm_rawd;

  always #5 clk = ~clk;

  mem_lsu #(.AW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .memwrite (memwrite),
    .bytes    (bytes),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .misalign (misalign),
    .dm_a     (dm_a),
    .dm_we    (dm_we),
    .dm_wd    (dm_wd),
    .dm_bytes (dm_bytes),
    .dm_rd    (dm_rd),
    .dm_rawd  (dm_rawd)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // dmem model: 16 words, sign-extending read port, write on the clock edge
  logic [31:0] mem [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (dm_we) mem[dm_a[5:2]] <= dm_wd;
  end

  assign dm_rawd = mem[dm_a[5:2]];

  always_comb begin
    dm_rd = dm_rawd;
    case (dm_bytes)
      2'd1: begin
        case (dm_a[1:0])
          2'd0:    dm_rd = {{24{dm_rawd[7]}},  dm_rawd[7:0]};
          2'd1:    dm_rd = {{24{dm_rawd[15]}}, dm_rawd[15:8]};
          2'd2:    dm_rd = {{24{dm_rawd[23]}}, dm_rawd[23:16]};
          default: dm_rd = {{24{dm_rawd[31]}}, dm_rawd[31:24]};
        endcase
      end
      2'd2: dm_rd = dm_a[1] ? {{16{dm_rawd[31]}}, dm_rawd[31:16]}
                            : {{16{dm_rawd[15]}}, dm_rawd[15:0]};
      default: dm_rd = dm_rawd;
    endcase
  end

  int checks = 0;
  int errs   = 0;
  logic [31:0] ref_mem [16];

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] b);
    logic [31:0] w, x;
    w = ref_mem[a[5:2]];
    if (b == 2'd1) begin
      x = (w >> (8 * a[1:0])) & 32'h0000_00FF;
      return x[7] ? (x | 32'hFFFF_FF00) : x;
    end else if (b == 2'd2) begin
      x = (w >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
      return x[15] ? (x | 32'hFFFF_0000) : x;
    end
    return w;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] a,
                                            input logic [1:0] b, input logic [31:0] d);
    int sh;
    if (b == 2'd1) begin
      sh = 8 * a[1:0];
      return (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
    end else if (b == 2'd2) begin
      sh = a[1] ? 16 : 0;
      return (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
    end
    return d;
  endfunction

  task automatic preload(input int i, input logic [31:0] v);
    pre_we  = 1'b1;
    pre_idx = i[3:0];
    pre_val = v;
    ref_mem[i] = v;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic do_op(input logic mw, input logic [1:0] b, input logic [31:0] a,
                       input logic [31:0] d, input string tag);
    bit mis, sub, exp_we;
    int idx;
    logic [31:0] exp_rd;
    mis    = TRAP && ((b == 2'd2 && a[0]) || ((b == 2'd0 || b == 2'd3) && a[1:0] != 2'b00));
    sub    = mw && (b == 2'd1 || b == 2'd2) && !mis;
    exp_we = mw && !sub && !mis;
    idx    = int'(a[5:2]);
    req = 1'b1; memwrite = mw; bytes = b; addr = a; wdata = d;
    #3;
    checks++;
    if (stall !== sub) begin errs++; $display("FAIL %s stall: got %b want %b", tag, stall, sub); end
    checks++;
    if (misalign !== mis) begin errs++; $display("FAIL %s misalign: got %b want %b", tag, misalign, mis); end
    checks++;
    if (dm_we !== exp_we) begin errs++; $display("FAIL %s dm_we: got %b want %b", tag, dm_we, exp_we); end
    if (!mw && !mis) begin
      exp_rd = ref_load(a, b);
      checks++;
      if (rdata !== exp_rd) begin errs++; $display("FAIL %s rdata: got %h want %h", tag, rdata, exp_rd); end
    end
    @(posedge clk); #1;
    if (sub) begin
      checks++;
      if (stall !== 1'b0 || dm_we !== 1'b1) begin
        errs++; $display("FAIL %s write_cycle: got stall=%b we=%b want stall=0 we=1", tag, stall, dm_we);
      end
      @(posedge clk); #1;
    end
    if (mw && !mis) ref_mem[idx] = ref_store(ref_mem[idx], a, b, d);
    req = 1'b0;
    checks++;
    if (mem[idx] !== ref_mem[idx]) begin
      errs++; $display("FAIL %s mem[%0d]: got %h want %h", tag, idx, mem[idx], ref_mem[idx]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; memwrite = 1'b0; bytes = 2'd0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #3;
    checks++;
    if (stall !== 1'b0 || dm_we !== 1'b0 || misalign !== 1'b0) begin
      errs++; $display("FAIL reset_outputs: got stall=%b we=%b mis=%b want 0 0 0", stall, dm_we, misalign);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) preload(i, $urandom);
  endtask

  task automatic test_byte_store();
    preload(1, 32'h1122_3344);
    do_op(1'b1, 2'd1, 32'h6, 32'h0000_00AB, "sb_lane2");
    checks++;
    if (mem[1] !== 32'h11AB_3344) begin errs++; $display("FAIL sb_value: got %h want 11ab3344", mem[1]); end
  endtask

  task automatic test_half_store();
    preload(1, 32'h1122_3344);
    do_op(1'b1, 2'd2, 32'h6, 32'h0000_BEEF, "sh_upper");
    checks++;
    if (mem[1] !== 32'hBEEF_3344) begin errs++; $display("FAIL sh_value: got %h want beef3344", mem[1]); end
  endtask

  task automatic test_word_store();
    do_op(1'b1, 2'd0, 32'h8, 32'hDEAD_BEEF, "sw");
    checks++;
    if (mem[2] !== 32'hDEAD_BEEF) begin errs++; $display("FAIL sw_value: got %h want deadbeef", mem[2]); end
  endtask

  task automatic test_back_to_back();
    preload(1, 32'h1122_3344);
    do_op(1'b1, 2'd1, 32'h6, 32'h0000_00AB, "b2b_sb");
    req = 1'b1; memwrite = 1'b0; bytes = 2'd1; addr = 32'h6;
    #3;
    checks++;
    if (rdata !== 32'hFFFF_FFAB) begin errs++; $display("FAIL b2b_lb: got %h want ffffffab", rdata); end
    @(posedge clk); #1;
    do_op(1'b1, 2'd2, 32'h4, 32'h0000_1234, "b2b_sh0");
    do_op(1'b1, 2'd1, 32'h7, 32'h0000_0099, "b2b_sb3");
    do_op(1'b0, 2'd0, 32'h4, 32'h0, "b2b_lw");
  endtask

  task automatic test_reset_mid_rmw();
    preload(2, 32'hCAFE_F00D);
    req = 1'b1; memwrite = 1'b1; bytes = 2'd1; addr = 32'h9; wdata = 32'h55;
    #3;
    @(posedge clk); #1;
    reset = 1'b1; req = 1'b0;
    #2;
    checks++;
    if (dm_we !== 1'b0) begin errs++; $display("FAIL rst_rmw_we: got %b want 0", dm_we); end
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    checks++;
    if (mem[2] !== 32'hCAFE_F00D) begin errs++; $display("FAIL rst_rmw_mem: got %h want cafef00d", mem[2]); end
    checks++;
    if (stall !== 1'b0 || dm_we !== 1'b0) begin
      errs++; $display("FAIL rst_rmw_idle: got stall=%b we=%b want 0 0", stall, dm_we);
    end
    do_op(1'b1, 2'd1, 32'h9, 32'h66, "rst_rmw_after");
  endtask

  task automatic test_misalign();
    preload(1, 32'h1122_3344);
    do_op(1'b1, 2'd2, 32'h5, 32'h0000_7777, "sh_addr5");
    do_op(1'b1, 2'd0, 32'hA, 32'h0BAD_F00D, "sw_addr10");
    do_op(1'b0, 2'd2, 32'h3, 32'h0, "lh_addr3");
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            32'($urandom_range(0, 63)), $urandom, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_byte_store();
    test_half_store();
    test_word_store();
    test_back_to_back();
    test_reset_mid_rmw();
    test_misalign();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
